// File: rtl/sad_disparity_scheduler_if.sv
// Column-fetch, SAD-result and search-control signals of the disparity scheduler.
// The scheduler uses the master modport; the surrounding datapath uses the slave modport.
interface sad_disparity_scheduler_if #(
    parameter int X_WIDTH    = 10,
    parameter int SAD_WIDTH  = 12,
    parameter int DISP_WIDTH = 6
);
    logic                  start_in;
    logic [X_WIDTH-1:0]    x_in;
    logic                  busy_out;
    logic                  sad_clear_out;
    logic                  col_req_out;
    logic [X_WIDTH-1:0]    col_left_x_out;
    logic [X_WIDTH-1:0]    col_right_x_out;
    logic                  col_ack_in;
    logic [SAD_WIDTH-1:0]  sad_result_in;
    logic                  sad_result_valid_in;
    logic [DISP_WIDTH-1:0] disp_out;
    logic [SAD_WIDTH-1:0]  min_sad_out;
    logic                  disp_valid_out;

    modport master (
        input  start_in, x_in, col_ack_in, sad_result_in, sad_result_valid_in,
        output busy_out, sad_clear_out, col_req_out, col_left_x_out, col_right_x_out,
               disp_out, min_sad_out, disp_valid_out
    );

    modport slave (
        output start_in, x_in, col_ack_in, sad_result_in, sad_result_valid_in,
        input  busy_out, sad_clear_out, col_req_out, col_left_x_out, col_right_x_out,
               disp_out, min_sad_out, disp_valid_out
    );
endinterface

// File: rtl/sad_disparity_scheduler.sv
// Drives one 3x3 SAD unit through a disparity search and reports the best-matching disparity.
// Define SAD_EARLY_EXIT_EN to end the search as soon as a zero SAD becomes the new best.
//
// state       | meaning
// ST_IDLE     | waiting for start_in
// ST_CLEAR    | one-cycle clear of the SAD window cache
// ST_FETCH    | three left/right column transfers for candidate d
// ST_WAIT_SAD | waiting for the SAD result of candidate d
// ST_DONE     | publish best disparity and minimum SAD
module sad_disparity_scheduler #(
    parameter int MAX_DISP   = 16,
    parameter int IMG_WIDTH  = 320,
    parameter int X_WIDTH    = 10,
    parameter int SAD_WIDTH  = 12,
    parameter int DISP_WIDTH = 6
) (
    input logic clk_in,
    input logic rst_in,
    sad_disparity_scheduler_if.master bus
);
    localparam int XS = X_WIDTH + 2;
    localparam logic signed [XS-1:0] XS_ONE  = XS'(1);
    localparam logic signed [XS-1:0] IMG_MAX = XS'(IMG_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_WAIT_SAD,
        ST_DONE
    } state_t;

    state_t                state_q;
    logic [X_WIDTH-1:0]    x_q;
    logic [X_WIDTH-1:0]    left_q, right_q;
    logic [X_WIDTH-1:0]    left_d, right_d;
    logic [DISP_WIDTH-1:0] d_q, d_max_q, best_d_q, disp_q;
    logic [1:0]            k_q, k_d;
    logic [SAD_WIDTH-1:0]  best_sad_q, min_sad_q;
    logic                  sad_clear_q, col_req_q, disp_valid_q;
    logic                  sad_better, last_cand;
    logic signed [XS-1:0]  left_s, right_s;

    function automatic logic [X_WIDTH-1:0] clamp_x(input logic signed [XS-1:0] v);
        if (v[XS-1]) begin
            return '0;
        end else if (v > IMG_MAX) begin
            return X_WIDTH'(IMG_WIDTH - 1);
        end
        return v[X_WIDTH-1:0];
    endfunction

    // Address for the tap loaded at the next edge: k=0 when leaving CLEAR, k+1 inside FETCH.
    always_comb begin
        k_d        = (state_q == ST_FETCH) ? k_q + 2'd1 : 2'd0;
        left_s     = $signed({2'b00, x_q}) + $signed({{(XS-2){1'b0}}, k_d}) - XS_ONE;
        right_s    = left_s - $signed({{(XS-DISP_WIDTH){1'b0}}, d_q});
        left_d     = clamp_x(left_s);
        right_d    = clamp_x(right_s);
        sad_better = bus.sad_result_in < best_sad_q;
`ifdef SAD_EARLY_EXIT_EN
        last_cand  = (d_q == d_max_q) || (sad_better && (bus.sad_result_in == '0));
`else
        last_cand  = (d_q == d_max_q);
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            d_q          <= '0;
            d_max_q      <= '0;
            k_q          <= '0;
            best_sad_q   <= '1;
            best_d_q     <= '0;
            left_q       <= '0;
            right_q      <= '0;
            sad_clear_q  <= 1'b0;
            col_req_q    <= 1'b0;
            disp_q       <= '0;
            min_sad_q    <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            sad_clear_q  <= 1'b0;
            disp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_in) begin
                        x_q <= bus.x_in;
                        if (bus.x_in > X_WIDTH'(MAX_DISP - 1)) begin
                            d_max_q <= DISP_WIDTH'(MAX_DISP - 1);
                        end else begin
                            d_max_q <= bus.x_in[DISP_WIDTH-1:0];
                        end
                        d_q         <= '0;
                        best_sad_q  <= '1;
                        best_d_q    <= '0;
                        sad_clear_q <= 1'b1;
                        state_q     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    k_q       <= '0;
                    col_req_q <= 1'b1;
                    left_q    <= left_d;
                    right_q   <= right_d;
                    state_q   <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (bus.col_ack_in) begin
                        if (k_q == 2'd2) begin
                            col_req_q <= 1'b0;
                            state_q   <= ST_WAIT_SAD;
                        end else begin
                            k_q     <= k_d;
                            left_q  <= left_d;
                            right_q <= right_d;
                        end
                    end
                end
                ST_WAIT_SAD: begin
                    if (bus.sad_result_valid_in) begin
                        if (sad_better) begin
                            best_sad_q <= bus.sad_result_in;
                            best_d_q   <= d_q;
                        end
                        if (last_cand) begin
                            state_q <= ST_DONE;
                        end else begin
                            d_q         <= d_q + DISP_WIDTH'(1);
                            sad_clear_q <= 1'b1;
                            state_q     <= ST_CLEAR;
                        end
                    end
                end
                ST_DONE: begin
                    disp_q       <= best_d_q;
                    min_sad_q    <= best_sad_q;
                    disp_valid_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_out        = (state_q != ST_IDLE);
    assign bus.sad_clear_out   = sad_clear_q;
    assign bus.col_req_out     = col_req_q;
    assign bus.col_left_x_out  = left_q;
    assign bus.col_right_x_out = right_q;
    assign bus.disp_out        = disp_q;
    assign bus.min_sad_out     = min_sad_q;
    assign bus.disp_valid_out  = disp_valid_q;
endmodule

// File: tb/tb_sad_disparity_scheduler.sv
// Scoreboard bench for sad_disparity_scheduler: a search-level model queues expected fetches and
// results, responders play line buffer and SAD unit, and a negedge monitor checks the DUT.
module tb_sad_disparity_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sad_disparity_scheduler_if #(.X_WIDTH(10), .SAD_WIDTH(12), .DISP_WIDTH(6)) bus ();

    sad_disparity_scheduler #(
        .MAX_DISP(16), .IMG_WIDTH(320), .X_WIDTH(10), .SAD_WIDTH(12), .DISP_WIDTH(6)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus(bus.master)
    );

    logic       main_start = 1'b0, spur_start = 1'b0;
    logic [9:0] main_x = '0, spur_x = '0;
    logic       ack = 1'b0, resp_v = 1'b0, spur_v = 1'b0;
    logic [11:0] resp_val = '0;

    assign bus.start_in            = main_start | spur_start;
    assign bus.x_in                = spur_start ? spur_x : main_x;
    assign bus.col_ack_in          = ack;
    assign bus.sad_result_valid_in = resp_v | spur_v;
    assign bus.sad_result_in       = resp_v ? resp_val : 12'd0;

    int checks = 0;
    int errors = 0;
    int sad_tab[16];
    int ack_mode = 0, spur_en = 0, resp_dly_max = 0;
    int cand = 0, xfer_cnt = 0, stall_cnt = 0, clear_cnt = 0;
    int block_cand = -1, reached_block = 0;
    int exp_fl[$], exp_fr[$], exp_disp[$], exp_sad[$], exp_ncand[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int clampx(input int v);
        if (v < 0) return 0;
        if (v > 319) return 319;
        return v;
    endfunction

    // Whole search computed from the rules: candidate list, tap addresses, strict minimum.
    task automatic push_model(input int x);
        int dmax, best, bd, n;
        dmax = (x < 15) ? x : 15;
        best = 4095;
        bd   = 0;
        n    = 0;
        for (int d = 0; d <= dmax; d++) begin
            n++;
            for (int k = 0; k < 3; k++) begin
                exp_fl.push_back(clampx(x - 1 + k));
                exp_fr.push_back(clampx(x - 1 + k - d));
            end
            if (sad_tab[d] < best) begin
                best = sad_tab[d];
                bd   = d;
`ifdef SAD_EARLY_EXIT_EN
                if (best == 0) break;
`endif
            end
        end
        exp_disp.push_back(bd);
        exp_sad.push_back(best);
        exp_ncand.push_back(n);
    endtask

    task automatic flush_exp();
        exp_fl.delete();
        exp_fr.delete();
        exp_disp.delete();
        exp_sad.delete();
        exp_ncand.delete();
    endtask

    // Line-buffer ack driver plus spurious start / result injector.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            spur_v     = 1'b0;
            spur_start = 1'b0;
            case (ack_mode)
                0: ack = 1'b1;
                1: ack = ($urandom_range(0, 3) != 0);
                default: begin
                    if (bus.col_req_out && xfer_cnt == 1 && stall_cnt < 4) begin
                        ack = 1'b0;
                        stall_cnt++;
                    end else begin
                        ack = 1'b1;
                    end
                end
            endcase
            if (spur_en != 0 && bus.col_req_out && $urandom_range(0, 2) == 0) spur_v = 1'b1;
            if (spur_en != 0 && bus.busy_out && $urandom_range(0, 5) == 0) begin
                spur_start = 1'b1;
                spur_x     = 10'($urandom_range(0, 319));
            end
        end
    end

    // SAD unit: answers after every third column transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.col_req_out && bus.col_ack_in) begin
                xfer_cnt++;
                stall_cnt = 0;
                if (xfer_cnt == 3) begin
                    xfer_cnt = 0;
                    if (cand == block_cand) begin
                        reached_block = 1;
                        cand++;
                    end else begin
                        @(posedge clk);
                        #1;
                        repeat ($urandom_range(0, resp_dly_max)) begin
                            @(posedge clk);
                            #1;
                        end
                        resp_val = (cand < 16) ? 12'(sad_tab[cand]) : 12'hfff;
                        resp_v   = 1'b1;
                        cand++;
                        @(posedge clk);
                        #1;
                        resp_v = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: pops expected fetches on each transfer and expected results on disp_valid_out.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.sad_clear_out) clear_cnt++;
                if (bus.col_req_out) begin
                    if (exp_fl.size() == 0) begin
                        chk("unexpected_fetch", 1, 0);
                    end else begin
                        chk("fetch_left", int'(bus.col_left_x_out), exp_fl[0]);
                        chk("fetch_right", int'(bus.col_right_x_out), exp_fr[0]);
                        if (bus.col_ack_in) begin
                            void'(exp_fl.pop_front());
                            void'(exp_fr.pop_front());
                        end
                    end
                end
                if (bus.disp_valid_out) begin
                    if (exp_disp.size() == 0) begin
                        chk("unexpected_disp_valid", 1, 0);
                    end else begin
                        chk("disp_out", int'(bus.disp_out), exp_disp.pop_front());
                        chk("min_sad_out", int'(bus.min_sad_out), exp_sad.pop_front());
                        chk("candidates", clear_cnt, exp_ncand.pop_front());
                        chk("fetches_left_over", exp_fl.size(), 0);
                        clear_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic run_search(input int x, input int ack_m, input int spur, output int cyc);
        int done;
        push_model(x);
        cand      = 0;
        clear_cnt = 0;
        ack_mode  = ack_m;
        spur_en   = spur;
        @(posedge clk);
        #1;
        main_x     = 10'(x);
        main_start = 1'b1;
        cyc  = 0;
        done = 0;
        while (done == 0 && cyc < 3000) begin
            @(posedge clk);
            cyc++;
            if (cyc == 1) begin
                #1;
                main_start = 1'b0;
            end
            @(negedge clk);
            if (bus.disp_valid_out) done = 1;
        end
        chk("search_done", done, 1);
        if (done == 0) flush_exp();
        @(posedge clk);
        #1;
        spur_en = 0;
        chk("queues_drained", exp_disp.size() + exp_fl.size(), 0);
    endtask

    task automatic load_ramp();
        for (int d = 0; d < 16; d++) sad_tab[d] = 50 - 2 * d;
        sad_tab[7] = 3;
    endtask

    initial begin
        int cyc, x, waited;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(bus.busy_out), 0);
        chk("rst_col_req", int'(bus.col_req_out), 0);
        chk("rst_disp_valid", int'(bus.disp_valid_out), 0);
        chk("rst_disp", int'(bus.disp_out), 0);
        chk("rst_min_sad", int'(bus.min_sad_out), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        load_ramp();
        run_search(100, 0, 0, cyc);
        chk("latency_x100", cyc, 82);

        sad_tab[0] = 20; sad_tab[1] = 10; sad_tab[2] = 15; sad_tab[3] = 10; sad_tab[4] = 12;
        run_search(4, 0, 0, cyc);
        chk("latency_x4", cyc, 27);

        sad_tab[0] = 77;
        run_search(0, 0, 0, cyc);
        run_search(319, 1, 0, cyc);

        load_ramp();
        run_search(100, 2, 0, cyc);

        // Abandon a search mid-wait and confirm it leaves no trace.
        load_ramp();
        push_model(100);
        cand = 0; clear_cnt = 0; ack_mode = 0; block_cand = 5; reached_block = 0;
        @(posedge clk);
        #1;
        main_x = 10'd100;
        main_start = 1'b1;
        @(posedge clk);
        #1;
        main_start = 1'b0;
        waited = 0;
        while (reached_block == 0 && waited < 500) begin
            @(posedge clk);
            waited++;
        end
        chk("reached_wait_d5", reached_block, 1);
        repeat (2) @(posedge clk);
        #1;
        flush_exp();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(bus.busy_out), 0);
        chk("abort_disp_valid", int'(bus.disp_valid_out), 0);
        chk("abort_disp", int'(bus.disp_out), 0);
        chk("abort_col_req", int'(bus.col_req_out), 0);
        repeat (8) @(posedge clk);
        block_cand = -1; reached_block = 0; cand = 0; xfer_cnt = 0; stall_cnt = 0;
        run_search(100, 0, 0, cyc);
        chk("latency_after_abort", cyc, 82);

        run_search(100, 1, 1, cyc);

        load_ramp();
        sad_tab[2] = 0;
        run_search(100, 0, 0, cyc);

        for (int i = 0; i < 25; i++) begin
            x = (i % 4 == 0) ? $urandom_range(0, 20) : $urandom_range(0, 319);
            for (int d = 0; d < 16; d++) begin
                sad_tab[d] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4095)
                                                         : $urandom_range(0, 40);
            end
            resp_dly_max = $urandom_range(0, 2);
            run_search(x, $urandom_range(0, 2), $urandom_range(0, 1), cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
